acc_seq_ctrl: RTL and testbench

//   Sequencer for the 8-bit accumulator datapath (adder -> clear/sum mux -> load register).

---
 rtl/acc_pkg.sv | 21 ++
 rtl/acc_seq_ctrl.sv | 106 ++++++++++
 tb/tb_acc_seq_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// ----------------------------------------------------------------------------
// acc_pkg : shared types and default widths for the accumulator sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package acc_pkg;

   localparam int c_DW_DEFAULT = 8;
   localparam int c_CW_DEFAULT = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_ACCUM = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/acc_seq_ctrl.sv
// ----------------------------------------------------------------------------
// acc_seq_ctrl : clears an 8-bit accumulator datapath, feeds it N operands
//                over valid/ready, then returns the final sum with a done pulse
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module acc_seq_ctrl
   import acc_pkg::*;
#(
   parameter int DW = c_DW_DEFAULT,
   parameter int CW = c_CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] count,
   input  logic          op_valid,
   input  logic [DW-1:0] op_data,
   output logic          op_ready,
   input  logic [DW-1:0] acc_q,
   output logic [DW-1:0] dp_a,
   output logic          dp_s,
   output logic          dp_l,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] result
);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_remaining;
   logic          r_done;
   logic [DW-1:0] r_result;
   logic          w_xfer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // remaining is only meaningful from CLEAR onwards; it is loaded on the accepting edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_remaining <= '0;
         r_done      <= 1'b0;
         r_result    <= '0;
      end else begin
         r_done <= (w_state_nxt == S_DONE);
         if (r_state == S_IDLE && start) begin
            r_remaining <= count;
         end else if (w_xfer) begin
            r_remaining <= r_remaining - 1'b1;
         end
         if (r_state == S_DONE) begin
            r_result <= acc_q;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      op_ready    = 1'b0;
      dp_a        = '0;
      dp_s        = 1'b0;
      dp_l        = 1'b0;
      w_xfer      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            dp_l        = 1'b1;
            w_state_nxt = (r_remaining == '0) ? S_DONE : S_ACCUM;
         end
         S_ACCUM: begin
            op_ready = 1'b1;
            dp_a     = op_data;
            dp_s     = 1'b1;
            dp_l     = op_valid;
            w_xfer   = op_valid;
            if (op_valid && r_remaining == CW'(1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = r_done;
   assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_acc_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_acc_seq_ctrl : directed jobs against acc_seq_ctrl paired with a model of
//                   the accumulator datapath (clear/sum mux into a load register)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_acc_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] count = '0;
   logic       op_valid = 1'b0;
   logic [7:0] op_data = '0;
   logic       op_ready;
   logic [7:0] acc_q = 8'h5A;
   logic [7:0] dp_a;
   logic       dp_s;
   logic       dp_l;
   logic       busy;
   logic       done;
   logic [7:0] result;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   // datapath register has no reset, so it starts and may remain stale
   always @(posedge clk) begin
      if (dp_l) acc_q <= dp_s ? acc_q + dp_a : 8'd0;
   end

   acc_seq_ctrl #(.DW(8), .CW(4)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .count    (count),
      .op_valid (op_valid),
      .op_data  (op_data),
      .op_ready (op_ready),
      .acc_q    (acc_q),
      .dp_a     (dp_a),
      .dp_s     (dp_s),
      .dp_l     (dp_l),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Runs one job from IDLE; ops packed LSB-first, a stall of 'gap' cycles before
   // the second operand, and an optional stray start (count=7) at cycle start_at.
   task automatic job(input string tag, input int cnt, input logic [31:0] ops,
                      input int gap, input int start_at, input int exp_res);
      int cyc, idx, gapc, done_cyc, rdy_cnt, busy_at_done;
      @(posedge clk); #1;
      start = 1'b1; count = 4'(cnt); op_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; idx = 0; gapc = 0; done_cyc = -1; rdy_cnt = 0; busy_at_done = -1;
      while (cyc < 40 && done_cyc < 0) begin
         if (cyc == start_at) begin
            start = 1'b1; count = 4'd7;
         end else begin
            start = 1'b0;
         end
         if (idx < cnt && !(idx == 1 && gapc < gap)) begin
            op_valid = 1'b1; op_data = ops[8*idx +: 8];
         end else begin
            op_valid = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            done_cyc = cyc; busy_at_done = int'(busy);
         end
         if (op_ready) rdy_cnt++;
         if (op_ready && op_valid) begin
            idx++;
         end else if (op_ready && idx == 1) begin
            check({tag, " stall_no_load"}, int'(dp_l), 0);
            gapc++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0; op_valid = 1'b0;
      check({tag, " latency"}, done_cyc, cnt + 2 + gap);
      check({tag, " ready_cycles"}, rdy_cnt, cnt + gap);
      check({tag, " busy_at_done"}, busy_at_done, 1);
      @(negedge clk);
      check({tag, " result"}, int'(result), exp_res);
      check({tag, " done_pulse_end"}, int'(done), 0);
      check({tag, " busy_after"}, int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1;
      op_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      check("rst result", int'(result), 0);
      check("rst op_ready", int'(op_ready), 0);
      check("rst dp_l", int'(dp_l), 0);
      check("rst dp_s", int'(dp_s), 0);
      check("rst dp_a", int'(dp_a), 0);
      #1 rst = 1'b0;
      op_valid = 1'b0;

      job("t1", 3, {8'd0, 8'd9, 8'd7, 8'd5}, 0, -1, 21);
      job("t2", 2, {8'd0, 8'd0, 8'd20, 8'd10}, 2, -1, 30);
      job("t3", 0, 32'd0, 0, -1, 0);
      job("t4a", 2, {8'd0, 8'd0, 8'd100, 8'd200}, 0, -1, 44);
      job("t4b", 1, {8'd0, 8'd0, 8'd0, 8'd3}, 0, -1, 3);

      // reset in the middle of a 4-operand job after two transfers
      @(posedge clk); #1;
      start = 1'b1; count = 4'd4; op_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; op_valid = 1'b1; op_data = 8'd11;
      @(posedge clk); #1;
      @(posedge clk); #1;
      op_data = 8'd12;
      @(posedge clk); #1;
      op_valid = 1'b0;
      check("t5 busy_before_rst", int'(busy), 1);
      rst = 1'b1;
      #1;
      check("t5 busy", int'(busy), 0);
      check("t5 result", int'(result), 0);
      check("t5 op_ready", int'(op_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      job("t5b", 1, {8'd0, 8'd0, 8'd0, 8'd6}, 0, -1, 6);

      job("t6", 2, {8'd0, 8'd0, 8'd2, 8'd1}, 0, 2, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
